reg_writeback_ctrl: RTL and testbench
=====================================

# reg_writeback_ctrl

Write-side controller for the core's `register_file`. It is the single initiator of `wr_en`/`wr_reg`/`wr_data`. It arbitrates single-cycle ALU results against variable-latency load returns, buffering load data in a 2-entry queue. It also keeps a per-register busy scoreboard for outstanding loads, which decode uses to stall RAW/WAW hazards. It sits between the execute/memory stages and the register file's write port.

## Interface
- `DATA_WIDTH`, default 32: register width.
- `NUM_REGS`, default 32: register count; index width is `$clog2(NUM_REGS)`.
- `MAX_LOADS`, default 4: maximum outstanding issued loads.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `issue_valid` in 1: decode presents an instruction this cycle.
- `issue_is_load` in 1: the presented instruction is a load.
- `issue_rd` in 5: destination register of the issued instruction.
- `issue_rs1`, `issue_rs2` in 5: source registers of the issued instruction.
- `issue_stall` out 1: combinational; instruction must be held.
- `alu_valid` in 1: ALU result valid; cannot be back-pressured.
- `alu_rd` in 5, `alu_data` in 32: ALU destination and result.
- `ld_valid` in 1, `ld_ready` out 1: load-return handshake.
- `ld_rd` in 5, `ld_data` in 32: load destination and data.
- `wr_en` out 1, `wr_reg` out 5, `wr_data` out 32: registered outputs to the `register_file` write port.
- `busy` out 32: scoreboard bits; bit 0 is hard-wired 0.
- `loads_pending` out 3: outstanding load count, 0..`MAX_LOADS`.

## Operation
- Load accept: a load is accepted when `ld_valid && ld_ready`.
- `ld_ready` is `!queue_full`. It is registered and equals 1 after reset.
- Write-port priority each cycle:
  1. ALU, if `alu_valid`.
  2. Otherwise, the head of the load queue.
  3. Otherwise, an incoming accepted load, which bypasses the queue.
- Accepted loads that do not win the port enter the queue in order. Queue order always equals accept order.
- Any winning source with rd = 0 produces `wr_en = 0` and is discarded. If it was a load, it is still retired.
- Scoreboard set: on `issue_valid && !issue_stall && issue_is_load && issue_rd != 0`, set `busy[issue_rd]` and increment `loads_pending`.
- Scoreboard clear: on the edge where a load write commits (`wr_en` high from the load path), clear `busy[wr_reg]` and decrement `loads_pending`.
- Set and clear of the same register on the same edge: set wins, and the count is unchanged net.
- `issue_stall` is high when `issue_valid` and any of these hold:
  - `busy[issue_rs1]` or `busy[issue_rs2]`;
  - `issue_is_load && busy[issue_rd]` (WAW);
  - `issue_is_load && loads_pending == MAX_LOADS`.
- A load return to a non-busy register is a protocol violation and must be flagged by an assertion. Behaviour is otherwise unchanged.

## Timing
- Source win at edge k: `wr_*` are driven after edge k, and `register_file` writes at edge k+1.
- Busy clear happens at edge k+1. `busy` therefore stays high while the write is on the port, so no read can see stale data.
- Load latency with an idle port: 1 cycle. It becomes 1 + n cycles when the ALU wins n consecutive cycles.
- Queue full (2 entries): `ld_ready` is low from the next cycle. The ALU continues unaffected.
- Reset, including mid-operation, forces:
  - `wr_en = 0`, `wr_reg = 0`, `wr_data = 0`;
  - `busy = 0`, `loads_pending = 0`;
  - queue empty, `ld_ready = 1`.
- In-flight loads are dropped on reset.

## Structure
- Shared package `reg_wb_pkg` holds:
  - `reg_idx_t`;
  - `wb_entry_t` struct {rd, data};
  - `wb_src_e` enum {WB_NONE, WB_ALU, WB_LOAD};
  - constants `NUM_REGS`, `DATA_WIDTH`, `MAX_LOADS`.
- One sub-module: `wb_load_queue`, a 2-entry FIFO of `wb_entry_t` with push/pop/full/empty.
- Top level holds the arbiter, output registers, scoreboard and counter.
- Assertions live in `reg_writeback_ctrl_assert`, bound like other blocks. It checks:
  - never `wr_en && wr_reg == 0`;
  - `busy[0] == 0`;
  - `loads_pending <= MAX_LOADS`.

## Test plan
- Idle ALU writes:
  - stimulus: `alu_valid=1`, `alu_rd=5`, `alu_data=32'hDEADBEEF` at edge k;
  - required: `wr_en=1`, `wr_reg=5`, `wr_data=DEADBEEF` after k; `register_file` x5 reads DEADBEEF after k+1.
- Load scoreboard:
  - stimulus: issue a load to x7; return `ld_data=32'h12345678` 3 cycles later;
  - required: `busy[7]=1` and dependent issue with rs1=7 sees `issue_stall=1` until the edge after the write; x7 then equals 12345678.
- Contention:
  - stimulus: `alu_valid` held for 4 cycles while loads to x3, x4, x5 return back-to-back;
  - required: the ALU writes all 4 cycles; `ld_ready` drops after x3 and x4 are queued; then writes x3, x4, x5 in order.
- x0 suppression:
  - stimulus: ALU to rd=0 with data FFFFFFFF, and a load issued to x0;
  - required: `wr_en` stays 0, `busy` is unchanged, and x0 reads 0.
- Limits:
  - stimulus: 4 loads issued to x1–x4;
  - required: the 5th load issue stalls; returning the x1 load releases it the next cycle.
- Reset:
  - stimulus: assert `rst_n=0` with 2 queued loads and `busy=0x1E`;
  - required: all outputs are at reset values immediately (asynchronous), and `ld_ready=1`.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types and sizing constants for the register write-back controller.
// Pure declarations, no logic.
// Widths here fix the load-queue entry layout used by the controller.
package reg_wb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int MAX_LOADS  = 4;

  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int LOAD_CNT_W = $clog2(MAX_LOADS + 1);

  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  rd;
    reg_data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_assert.sv
// Protocol and invariant checks for reg_writeback_ctrl, attached by bind.
// No latency; observes only.
// No backpressure; checks are disabled while reset is asserted.
module reg_writeback_ctrl_assert
  import reg_wb_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  input logic                  wr_en,
  input reg_idx_t              wr_reg,
  input logic [NUM_REGS-1:0]   busy,
  input logic [LOAD_CNT_W-1:0] loads_pending,
  input logic                  ld_valid,
  input logic                  ld_ready,
  input reg_idx_t              ld_rd
);

  // x0 is architecturally constant, so the port must never target it.
  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && (wr_reg == '0)));

  // x0 can never be marked pending.
  a_busy0_zero: assert property (@(posedge clk) disable iff (!rst_n)
    busy[0] == 1'b0);

  // Decode's limit stall must keep the counter in range.
  a_pending_max: assert property (@(posedge clk) disable iff (!rst_n)
    loads_pending <= LOAD_CNT_W'(MAX_LOADS));

  // A returning load must match an outstanding scoreboard entry.
  a_load_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_valid && ld_ready && (ld_rd != '0)) |-> busy[ld_rd]);

endmodule

bind reg_writeback_ctrl reg_writeback_ctrl_assert u_wb_assert (
  .clk           (clk),
  .rst_n         (rst_n),
  .wr_en         (wr_en),
  .wr_reg        (wr_reg),
  .busy          (busy),
  .loads_pending (loads_pending),
  .ld_valid      (ld_valid),
  .ld_ready      (ld_ready),
  .ld_rd         (ld_rd)
);

// File: rtl/wb_load_queue.sv
// Two-entry in-order FIFO holding load returns that lost the write port.
// Latency: pushed entry is visible at head one cycle after push.
// Backpressure: full/empty are registered flags; caller must not push when full.
module wb_load_queue
  import reg_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;

  assign head = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; drives the registered flags.
  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers, occupancy and flags; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_next;
      full  <= (count_next == 2'd2);
      empty <= (count_next == 2'd0);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Sole driver of the register-file write port: ALU > queued load > bypassed load.
// Latency: winner appears on wr_* one edge after it wins; busy clears one edge later.
// Backpressure: ALU never stalls; loads see ld_ready low while the 2-entry queue is full.
module reg_writeback_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int MAX_LOADS  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  input  logic                             issue_is_load,
  input  logic [$clog2(NUM_REGS)-1:0]      issue_rd,
  input  logic [$clog2(NUM_REGS)-1:0]      issue_rs1,
  input  logic [$clog2(NUM_REGS)-1:0]      issue_rs2,
  output logic                             issue_stall,
  input  logic                             alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]            alu_data,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [$clog2(NUM_REGS)-1:0]      ld_rd,
  input  logic [DATA_WIDTH-1:0]            ld_data,
  output logic                             wr_en,
  output logic [$clog2(NUM_REGS)-1:0]      wr_reg,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic [NUM_REGS-1:0]              busy,
  output logic [$clog2(MAX_LOADS+1)-1:0]   loads_pending
);
  import reg_wb_pkg::*;

  localparam int CNT_W = $clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0] LOADS_LIMIT = CNT_W'(MAX_LOADS);

  logic          ld_acc;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  wb_entry_t     q_head;
  wb_entry_t     ld_entry;
  wb_src_e       win_src;
  wb_entry_t     win_entry;
  logic          win_wr;
  logic          wr_is_load;
  logic          issue_set;
  logic          load_clr;
  logic [NUM_REGS-1:0] busy_next;

  // Queue full flag is itself a register, so ld_ready is glitch-free.
  assign ld_ready = !q_full;
  assign ld_acc   = ld_valid && ld_ready;
  assign ld_entry = '{rd: ld_rd, data: ld_data};

  wb_load_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_entry (ld_entry),
    .pop        (q_pop),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty)
  );

  // Pick the write-port winner; accepted loads that lose go to the queue tail,
  // and a fresh load only bypasses when the queue is empty to keep accept order.
  always_comb begin
    win_src   = WB_NONE;
    win_entry = '0;
    q_pop     = 1'b0;
    q_push    = 1'b0;
    if (alu_valid) begin
      win_src   = WB_ALU;
      win_entry = '{rd: alu_rd, data: alu_data};
      q_push    = ld_acc;
    end else if (!q_empty) begin
      win_src   = WB_LOAD;
      win_entry = q_head;
      q_pop     = 1'b1;
      q_push    = ld_acc;
    end else if (ld_acc) begin
      win_src   = WB_LOAD;
      win_entry = ld_entry;
    end
  end

  // A winner targeting x0 is consumed without touching the port.
  assign win_wr = (win_src != WB_NONE) && (win_entry.rd != '0);

  // Registered write port; reg/data hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
      wr_is_load <= 1'b0;
    end else begin
      wr_en      <= win_wr;
      wr_is_load <= win_wr && (win_src == WB_LOAD);
      if (win_wr) begin
        wr_reg  <= win_entry.rd;
        wr_data <= win_entry.data;
      end
    end
  end

  // Hazard stall: RAW on either source, WAW on a load's destination, or no load slots.
  always_comb begin
    issue_stall = issue_valid &&
                  (busy[issue_rs1] || busy[issue_rs2] ||
                   (issue_is_load && (busy[issue_rd] || (loads_pending == LOADS_LIMIT))));
  end

  assign issue_set = issue_valid && !issue_stall && issue_is_load && (issue_rd != '0);
  // Clear only once the load data has been on the port for a full cycle.
  assign load_clr  = wr_en && wr_is_load;

  // Scoreboard update; a same-register set is applied after the clear so it wins.
  always_comb begin
    busy_next = busy;
    if (load_clr)  busy_next[wr_reg]   = 1'b0;
    if (issue_set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard bits and outstanding-load count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      loads_pending <= '0;
    end else begin
      busy <= busy_next;
      case ({issue_set, load_clr})
        2'b10:   loads_pending <= loads_pending + CNT_W'(1);
        2'b01:   loads_pending <= loads_pending - CNT_W'(1);
        default: loads_pending <= loads_pending;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: a cycle table plus hand-written
// sequences for queue contention, the load limit and asynchronous reset.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] busy;
  logic [2:0]  loads_pending;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  reg_writeback_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .busy(busy), .loads_pending(loads_pending)
  );

  // Register-file model fed by the write port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wr_en) begin
      rf[wr_reg] <= wr_data;
    end
  end

  typedef struct {
    logic        iv, il;
    logic [4:0]  ird, irs1, irs2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_stall, e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_dat, e_busy;
    logic [2:0]  e_lp;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int iv, il, ird, irs1, irs2, av, ard, input logic [31:0] adat,
                     input int lv, lrd, input logic [31:0] ldat,
                     input int e_stall, e_en, e_reg, input logic [31:0] e_dat, e_busy,
                     input int e_lp, e_rdy);
    vec_t v;
    v.iv = 1'(iv); v.il = 1'(il); v.ird = 5'(ird); v.irs1 = 5'(irs1); v.irs2 = 5'(irs2);
    v.av = 1'(av); v.ard = 5'(ard); v.adat = adat;
    v.lv = 1'(lv); v.lrd = 5'(lrd); v.ldat = ldat;
    v.e_stall = 1'(e_stall); v.e_en = 1'(e_en); v.e_reg = 5'(e_reg); v.e_dat = e_dat;
    v.e_busy = e_busy; v.e_lp = 3'(e_lp); v.e_rdy = 1'(e_rdy);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input int il, rd, rs1, rs2);
    issue_valid = 1'b1; issue_is_load = 1'(il);
    issue_rd = 5'(rd); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
  endtask

  // Issues loads to consecutive registers first..last, expecting no stall.
  task automatic issue_loads(input string tag, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      @(negedge clk);
      idle_inputs();
      drive_issue(1, r, 0, 0);
      #1;
      chk($sformatf("%s_issue_x%0d_stall", tag, r), 32'(issue_stall), 32'd0);
      tick();
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int ld_idx;
    logic       c_alu [8];
    logic       c_rdy [8];
    logic       c_en  [8];
    logic [4:0] c_reg [8];

    rst_n = 1'b0;
    idle_inputs();

    // Table: iv il ird rs1 rs2 | av ard adat | lv lrd ldat | stall | en reg dat | busy lp rdy
    add(0,0, 0,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            0,    0,1);
    add(0,0, 0,0,0, 1,5,32'hDEADBEEF, 0, 0,0,            0, 1, 5,32'hDEADBEEF, 0,    0,1);
    add(0,0, 0,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            0,    0,1);
    add(1,1, 7,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            'h80, 1,1);
    add(1,0, 9,7,0, 0,0,0,            0, 0,0,            1, 0, 0,0,            'h80, 1,1);
    add(1,0, 9,7,0, 0,0,0,            0, 0,0,            1, 0, 0,0,            'h80, 1,1);
    add(1,0, 9,7,0, 0,0,0,            1, 7,32'h12345678, 1, 1, 7,32'h12345678, 'h80, 1,1);
    add(1,0, 9,7,0, 0,0,0,            0, 0,0,            1, 0, 0,0,            0,    0,1);
    add(1,0, 9,7,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            0,    0,1);
    add(1,1, 0,0,0, 1,0,32'hFFFFFFFF, 0, 0,0,            0, 0, 0,0,            0,    0,1);
    add(0,0, 0,0,0, 0,0,0,            1, 0,32'hAAAA5555, 0, 0, 0,0,            0,    0,1);
    add(1,1,10,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            'h400,1,1);
    add(1,1,10,0,0, 0,0,0,            0, 0,0,            1, 0, 0,0,            'h400,1,1);
    add(1,1,10,0,0, 0,0,0,            1,10,32'hCAFE0010, 1, 1,10,32'hCAFE0010, 'h400,1,1);
    add(1,1,10,0,0, 0,0,0,            0, 0,0,            1, 0, 0,0,            0,    0,1);
    add(1,1,10,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            'h400,1,1);
    add(1,0, 2,0,10,0,0,0,            1,10,32'h00000001, 1, 1,10,32'h00000001, 'h400,1,1);
    add(0,0, 0,0,0, 0,0,0,            0, 0,0,            0, 0, 0,0,            0,    0,1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_reg", 32'(wr_reg), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_lp", 32'(loads_pending), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      issue_valid = vecs[i].iv; issue_is_load = vecs[i].il; issue_rd = vecs[i].ird;
      issue_rs1 = vecs[i].irs1; issue_rs2 = vecs[i].irs2;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_data = vecs[i].ldat;
      #1;
      chk($sformatf("row%0d_stall", i), 32'(issue_stall), 32'(vecs[i].e_stall));
      tick();
      chk($sformatf("row%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en) begin
        chk($sformatf("row%0d_wr_reg", i), 32'(wr_reg), 32'(vecs[i].e_reg));
        chk($sformatf("row%0d_wr_data", i), wr_data, vecs[i].e_dat);
      end
      chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("row%0d_lp", i), 32'(loads_pending), 32'(vecs[i].e_lp));
      chk($sformatf("row%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].e_rdy));
    end
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    chk("rf_x7", rf[7], 32'h12345678);
    chk("rf_x10", rf[10], 32'h00000001);
    chk("rf_x0", rf[0], 32'd0);

    // Contention: ALU holds the port 4 cycles while loads x3,x4,x5 return back-to-back.
    issue_loads("cont", 3, 5);
    c_alu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    c_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    c_en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    c_reg = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd3, 5'd4, 5'd5, 5'd0};
    ld_idx = 0;
    for (int c = 0; c < 8; c++) begin
      logic acc;
      @(negedge clk);
      idle_inputs();
      alu_valid = c_alu[c];
      alu_rd    = 5'(20 + c);
      alu_data  = 32'hA000_0000 + 32'(20 + c);
      ld_valid  = (ld_idx < 3);
      ld_rd     = 5'(3 + ld_idx);
      ld_data   = 32'h0000_0300 + 32'(3 + ld_idx);
      #1;
      chk($sformatf("cont_c%0d_ld_ready", c), 32'(ld_ready), 32'(c_rdy[c]));
      acc = ld_valid && ld_ready;
      tick();
      if (acc) ld_idx++;
      chk($sformatf("cont_c%0d_wr_en", c), 32'(wr_en), 32'(c_en[c]));
      if (c_en[c]) begin
        chk($sformatf("cont_c%0d_wr_reg", c), 32'(wr_reg), 32'(c_reg[c]));
        chk($sformatf("cont_c%0d_wr_data", c), wr_data,
            (c < 4) ? 32'hA000_0000 + 32'(c_reg[c]) : 32'h0000_0300 + 32'(c_reg[c]));
      end
      if (c == 3) chk("cont_busy_held", busy, 32'h38);
    end
    chk("cont_busy_end", busy, 32'd0);
    chk("cont_lp_end", 32'(loads_pending), 32'd0);

    // Limits: 4 outstanding loads block a 5th until x1 retires.
    issue_loads("lim", 1, 4);
    chk("lim_lp_full", 32'(loads_pending), 32'd4);
    drive_issue(1, 6, 0, 0);
    #1;
    chk("lim_5th_stall", 32'(issue_stall), 32'd1);
    tick();
    @(negedge clk);
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h0000_0011;
    #1;
    chk("lim_ret_stall", 32'(issue_stall), 32'd1);
    tick();
    chk("lim_ret_wr_reg", 32'(wr_reg), 32'd1);
    chk("lim_ret_lp", 32'(loads_pending), 32'd4);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("lim_port_stall", 32'(issue_stall), 32'd1);
    tick();
    chk("lim_clr_lp", 32'(loads_pending), 32'd3);
    chk("lim_clr_busy", busy, 32'h1C);
    @(negedge clk);
    #1;
    chk("lim_release_stall", 32'(issue_stall), 32'd0);
    tick();
    chk("lim_accept_lp", 32'(loads_pending), 32'd4);
    chk("lim_accept_busy", busy, 32'h5C);
    foreach (c_reg[k]) begin
      if (k < 4) begin
        @(negedge clk);
        idle_inputs();
        ld_valid = 1'b1;
        ld_rd    = (k == 3) ? 5'd6 : 5'(k + 2);
        ld_data  = 32'h0000_0050 + 32'(k);
        tick();
      end
    end
    @(negedge clk);
    idle_inputs();
    tick();
    tick();
    chk("lim_drain_busy", busy, 32'd0);
    chk("lim_drain_lp", 32'(loads_pending), 32'd0);

    // Asynchronous reset with two queued loads and busy = 0x1E.
    issue_loads("rst", 1, 4);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'(8 + c); alu_data = 32'h0000_0088 + 32'(c);
      ld_valid = 1'b1; ld_rd = 5'(1 + c); ld_data = 32'h0000_0077;
      tick();
    end
    chk("rst_pre_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_pre_busy", busy, 32'h1E);
    chk("rst_pre_wr_reg", 32'(wr_reg), 32'd9);
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en", 32'(wr_en), 32'd0);
    chk("rst_async_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_async_wr_data", wr_data, 32'd0);
    chk("rst_async_busy", busy, 32'd0);
    chk("rst_async_lp", 32'(loads_pending), 32'd0);
    chk("rst_async_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_after_wr_en", 32'(wr_en), 32'd0);
    chk("rst_after_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    chk("rst_after_wr_en2", 32'(wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
